jtag_tap_multi: RTL and testbench
=================================

# jtag_tap_multi

Parametrised JTAG test access port: IEEE 1149.1 16-state TAP controller with a configurable-width instruction register, mandatory BYPASS and IDCODE data registers, and NUM_DR user data registers. Each user register has separate capture and update stages with parallel ports. The block sits between the board-level JTAG pins (TMS/TDI/TDO, clocked by CLK) and on-chip debug/configuration logic. It is the multi-register, capture/update-capable successor of the fixed 4-bit-IR, two-register tap.

## Interface
- IR_WIDTH, 4, instruction register width; must satisfy NUM_DR+2 < 2**IR_WIDTH
- NUM_DR, 2, number of user data registers (1..8)
- DR_WIDTH, 8, width of every user data register (2..32)
- IDCODE, 32'h1000_0001, 32-bit device ID; bit 0 must be 1
- CLK  in  1  TCK; all state changes on the rising edge
- RESET  in  1  asynchronous, active-high reset
- TMS  in  1  test mode select
- TDI  in  1  serial data in
- TDO  out  1  serial data out (combinational)
- state  out  4  current TAP state (encoding below)
- ir  out  IR_WIDTH  active (updated) instruction
- dr_capture_data  in  NUM_DR*DR_WIDTH  parallel capture values; slice k = [k*DR_WIDTH +: DR_WIDTH]
- dr_update_data  out  NUM_DR*DR_WIDTH  parallel update (shadow) registers, same slicing
- update_dr  out  1  high while state==UPDATE_DR
- update_ir  out  1  high while state==UPDATE_IR
- dr_sel  out  NUM_DR  one-hot; bit k high while ir selects user DR k

## Operation
- State encoding: TLR 0, RTI 1, SEL_DR 2, CAP_DR 3, SHIFT_DR 4, EXIT1_DR 5, PAUSE_DR 6, EXIT2_DR 7, UPD_DR 8, SEL_IR 9, CAP_IR 10, SHIFT_IR 11, EXIT1_IR 12, PAUSE_IR 13, EXIT2_IR 14, UPD_IR 15.
- Transitions follow standard 1149.1. TMS=1/0 next states: TLR->TLR/RTI; RTI->SEL_DR/RTI; SEL_DR->SEL_IR/CAP_DR; CAP->EXIT1/SHIFT; SHIFT->EXIT1/SHIFT; EXIT1->UPD/PAUSE; PAUSE->EXIT2/PAUSE; EXIT2->UPD/SHIFT; UPD->SEL_DR/RTI; SEL_IR->TLR/CAP_IR. The same pattern applies to the IR column.
- Opcodes: 1 = IDCODE; 2+k = user DR k; all others, including all-ones, = BYPASS.
- IR path:
  - CAP_IR loads ir_shift with {0…0,01}.
  - SHIFT_IR does ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]}.
  - UPD_IR does ir <= ir_shift.
- Entering TLR by any route forces ir to the IDCODE opcode (1).
- DR path (selected by ir):
  - CAP_DR loads the selected shift register:
    - BYPASS: 1'b0
    - IDCODE: IDCODE
    - user k: dr_capture_data slice k
  - SHIFT_DR shifts right with TDI into the MSB. Widths are 1 for BYPASS, 32 for IDCODE, and DR_WIDTH for user registers.
  - UPD_DR: for user k, dr_update_data slice k <= shift register k. BYPASS and IDCODE have no update stage.
- Unselected registers hold their value.
- TDO selection:
  - state==SHIFT_IR: ir_shift[0]
  - state==SHIFT_DR: bit 0 of the selected DR shift register
  - otherwise: 0

## Timing
- RESET asserted, effective immediately:
  - state=TLR, ir=1, ir_shift=0
  - all DR shift registers = 0
  - dr_update_data=0
  - resulting outputs: TDO=0, update_dr=update_ir=0, dr_sel=0
- Reset mid-shift discards the partial shift and leaves dr_update_data=0.
- Five consecutive TMS=1 edges reach TLR from any state. On the edge that enters TLR, ir becomes 1.
- Capture, shift and update actions occur on the rising edge taken while in the named state. Example: dr_update_data changes on the edge leaving UPD_DR, i.e. one cycle after update_dr rises.
- TDO is combinational from state and shift-register bit 0. It is valid throughout each SHIFT cycle and is sampled by the host before the shifting edge.
- ir changes only on the edge leaving UPD_IR (or on entering TLR). A DR scan uses the ir value held at CAP_DR.
- BYPASS adds exactly one cycle of TDI->TDO delay in SHIFT_DR.
- update_dr and update_ir are single-cycle pulses per visit to the update state; they are not asserted in TLR.

## Test plan
- Reset: assert RESET mid-SHIFT_DR → state=0, ir=1, dr_update_data=0, TDO=0.
- IDCODE readout:
  - Stimulus: from TLR, TMS 0,1,0,0, then 32 SHIFT_DR cycles.
  - Required response: TDO bits LSB-first equal IDCODE 0x10000001.
- IR capture/update:
  - Stimulus: shift opcode 4'b0010 into the IR; capture the TDO bits during the shift.
  - Required response: first two TDO bits are 1,0; ir=2 after UPD_IR; dr_sel=2'b01.
- User DR write:
  - Stimulus: ir=2, dr_capture_data slice0=0xA5, shift in 0x3C.
  - Required response: TDO yields 0xA5 LSB-first; after UPD_DR, slice0=0x3C and slice1 is unchanged (0).
- BYPASS:
  - Stimulus: ir=4'hF, shift TDI pattern 1,0,1,1.
  - Required response: TDO = 0 (captured), 1, 0, 1.
- TMS reset and PAUSE:
  - Stimulus: from SHIFT_IR with ir=3, apply TMS=1 ×5.
  - Required response: state=TLR and ir=1.
  - Stimulus: a DR scan through PAUSE_DR/EXIT2_DR.
  - Required response: shifting resumes without bit loss.

Source files
------------

// File: rtl/jtag_tap_multi.sv
// jtag_tap_multi: IEEE 1149.1 TAP controller with a configurable instruction
// register, BYPASS and IDCODE data registers, and NUM_DR user data registers.
// Each user register has a shift stage, loaded from a parallel capture port,
// and an update (shadow) stage that drives a parallel output port.
module jtag_tap_multi #(
    parameter int          IR_WIDTH = 4,
    parameter int          NUM_DR   = 2,
    parameter int          DR_WIDTH = 8,
    parameter logic [31:0] IDCODE   = 32'h1000_0001
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       TMS,
    input  logic                       TDI,
    output logic                       TDO,
    output logic [3:0]                 state,
    output logic [IR_WIDTH-1:0]        ir,
    input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture_data,
    output logic [NUM_DR*DR_WIDTH-1:0] dr_update_data,
    output logic                       update_dr,
    output logic                       update_ir,
    output logic [NUM_DR-1:0]          dr_sel
);

    typedef enum logic [3:0] {
        ST_TLR      = 4'd0,
        ST_RTI      = 4'd1,
        ST_SEL_DR   = 4'd2,
        ST_CAP_DR   = 4'd3,
        ST_SHIFT_DR = 4'd4,
        ST_EXIT1_DR = 4'd5,
        ST_PAUSE_DR = 4'd6,
        ST_EXIT2_DR = 4'd7,
        ST_UPD_DR   = 4'd8,
        ST_SEL_IR   = 4'd9,
        ST_CAP_IR   = 4'd10,
        ST_SHIFT_IR = 4'd11,
        ST_EXIT1_IR = 4'd12,
        ST_PAUSE_IR = 4'd13,
        ST_EXIT2_IR = 4'd14,
        ST_UPD_IR   = 4'd15
    } tap_state_t;

    localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);

    tap_state_t            state_reg;
    tap_state_t            state_next;
    logic [IR_WIDTH-1:0]   ir_reg;
    logic [IR_WIDTH-1:0]   ir_shift_reg;
    logic                  update_dr_reg;
    logic                  update_ir_reg;
    logic                  bypass_reg;
    logic [31:0]           idcode_shift_reg;
    logic [NUM_DR-1:0]     user_tdo;
    logic                  is_idcode;
    logic                  is_bypass;
    logic                  dr_tdo;

    // Standard 1149.1 next-state function driven by TMS
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_TLR:      state_next = TMS ? ST_TLR      : ST_RTI;
            ST_RTI:      state_next = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_DR:   state_next = TMS ? ST_SEL_IR   : ST_CAP_DR;
            ST_CAP_DR:   state_next = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_SHIFT_DR: state_next = TMS ? ST_EXIT1_DR : ST_SHIFT_DR;
            ST_EXIT1_DR: state_next = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
            ST_PAUSE_DR: state_next = TMS ? ST_EXIT2_DR : ST_PAUSE_DR;
            ST_EXIT2_DR: state_next = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
            ST_UPD_DR:   state_next = TMS ? ST_SEL_DR   : ST_RTI;
            ST_SEL_IR:   state_next = TMS ? ST_TLR      : ST_CAP_IR;
            ST_CAP_IR:   state_next = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_SHIFT_IR: state_next = TMS ? ST_EXIT1_IR : ST_SHIFT_IR;
            ST_EXIT1_IR: state_next = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
            ST_PAUSE_IR: state_next = TMS ? ST_EXIT2_IR : ST_PAUSE_IR;
            ST_EXIT2_IR: state_next = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
            ST_UPD_IR:   state_next = TMS ? ST_SEL_DR   : ST_RTI;
            default:     state_next = ST_TLR;
        endcase
    end

    // TAP state, instruction path and registered update pulses
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg     <= ST_TLR;
            ir_reg        <= OP_IDCODE;
            ir_shift_reg  <= '0;
            update_dr_reg <= 1'b0;
            update_ir_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            update_dr_reg <= (state_next == ST_UPD_DR);
            update_ir_reg <= (state_next == ST_UPD_IR);
            if (state_reg == ST_CAP_IR)
                ir_shift_reg <= IR_WIDTH'(1);
            else if (state_reg == ST_SHIFT_IR)
                ir_shift_reg <= {TDI, ir_shift_reg[IR_WIDTH-1:1]};
            // UPD_IR never leads to TLR, so the two ir writes cannot collide
            if (state_next == ST_TLR)
                ir_reg <= OP_IDCODE;
            else if (state_reg == ST_UPD_IR)
                ir_reg <= ir_shift_reg;
        end
    end

    assign is_idcode = (ir_reg == OP_IDCODE);
    assign is_bypass = !is_idcode && (dr_sel == '0);

    // BYPASS and IDCODE shift stages; neither has an update stage
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bypass_reg       <= 1'b0;
            idcode_shift_reg <= '0;
        end else begin
            if (is_bypass) begin
                if (state_reg == ST_CAP_DR)
                    bypass_reg <= 1'b0;
                else if (state_reg == ST_SHIFT_DR)
                    bypass_reg <= TDI;
            end
            if (is_idcode) begin
                if (state_reg == ST_CAP_DR)
                    idcode_shift_reg <= IDCODE;
                else if (state_reg == ST_SHIFT_DR)
                    idcode_shift_reg <= {TDI, idcode_shift_reg[31:1]};
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DR; gi++) begin : g_user
            logic [DR_WIDTH-1:0] shift_reg;
            logic [DR_WIDTH-1:0] update_reg;

            assign dr_sel[gi] = (ir_reg == IR_WIDTH'(gi + 2));

            // User register gi: capture, shift and update only while selected
            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    shift_reg  <= '0;
                    update_reg <= '0;
                end else if (dr_sel[gi]) begin
                    if (state_reg == ST_CAP_DR)
                        shift_reg <= dr_capture_data[gi*DR_WIDTH +: DR_WIDTH];
                    else if (state_reg == ST_SHIFT_DR)
                        shift_reg <= {TDI, shift_reg[DR_WIDTH-1:1]};
                    else if (state_reg == ST_UPD_DR)
                        update_reg <= shift_reg;
                end
            end

            assign user_tdo[gi] = shift_reg[0];
            assign dr_update_data[gi*DR_WIDTH +: DR_WIDTH] = update_reg;
        end
    endgenerate

    // dr_sel is one-hot or zero, so AND-OR picks the selected user bit
    assign dr_tdo = is_idcode    ? idcode_shift_reg[0] :
                    (|dr_sel)    ? |(user_tdo & dr_sel) :
                                   bypass_reg;

    assign TDO = (state_reg == ST_SHIFT_IR) ? ir_shift_reg[0] :
                 (state_reg == ST_SHIFT_DR) ? dr_tdo : 1'b0;

    assign state     = state_reg;
    assign ir        = ir_reg;
    assign update_dr = update_dr_reg;
    assign update_ir = update_ir_reg;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Testbench for jtag_tap_multi: directed JTAG scans, a behavioural model
// compared every cycle, and literal expectations for each scenario.
module tb_jtag_tap_multi;

    localparam int IRW = 4;
    localparam int NDR = 2;
    localparam int DRW = 8;
    localparam logic [31:0] IDC = 32'h1000_0001;

    logic             CLK = 1'b0;
    logic             RESET = 1'b0;
    logic             TMS = 1'b1;
    logic             TDI = 1'b0;
    logic             TDO;
    logic [3:0]       state;
    logic [IRW-1:0]   ir;
    logic [NDR*DRW-1:0] dr_capture_data = '0;
    logic [NDR*DRW-1:0] dr_update_data;
    logic             update_dr;
    logic             update_ir;
    logic [NDR-1:0]   dr_sel;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    jtag_tap_multi #(
        .IR_WIDTH(IRW), .NUM_DR(NDR), .DR_WIDTH(DRW), .IDCODE(IDC)
    ) dut (
        .CLK(CLK), .RESET(RESET), .TMS(TMS), .TDI(TDI), .TDO(TDO),
        .state(state), .ir(ir),
        .dr_capture_data(dr_capture_data), .dr_update_data(dr_update_data),
        .update_dr(update_dr), .update_ir(update_ir), .dr_sel(dr_sel)
    );

    initial forever #5 CLK = ~CLK;

    // ---------------- behavioural model ----------------
    int nxt1 [16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int nxt0 [16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};

    int          m_state = 0;
    logic [3:0]  m_ir = 4'd1;
    logic [3:0]  m_irs = '0;
    logic        m_byp = 1'b0;
    logic [31:0] m_idc = '0;
    logic [7:0]  m_usr [NDR];
    logic [7:0]  m_upd [NDR];

    function automatic int selk(input logic [3:0] opc);
        if (opc == 4'd1) return -1;
        if (int'(opc) >= 2 && int'(opc) < 2 + NDR) return int'(opc) - 2;
        return -2;
    endfunction

    task automatic model_reset();
        m_state = 0; m_ir = 4'd1; m_irs = '0; m_byp = 1'b0; m_idc = '0;
        for (int k = 0; k < NDR; k++) begin m_usr[k] = '0; m_upd[k] = '0; end
    endtask

    task automatic model_step();
        int k;
        int nxt;
        k = selk(m_ir);
        case (m_state)
            3: if (k == -1) m_idc = IDC;
               else if (k == -2) m_byp = 1'b0;
               else m_usr[k] = dr_capture_data[k*DRW +: DRW];
            4: if (k == -1) m_idc = (m_idc >> 1) | (32'(TDI) << 31);
               else if (k == -2) m_byp = TDI;
               else m_usr[k] = (m_usr[k] >> 1) | (8'(TDI) << 7);
            8: if (k >= 0) m_upd[k] = m_usr[k];
            10: m_irs = 4'd1;
            11: m_irs = (m_irs >> 1) | (4'(TDI) << 3);
            15: m_ir = m_irs;
            default: ;
        endcase
        nxt = TMS ? nxt1[m_state] : nxt0[m_state];
        if (nxt == 0) m_ir = 4'd1;
        m_state = nxt;
    endtask

    function automatic logic exp_tdo();
        int k;
        k = selk(m_ir);
        if (m_state == 11) return m_irs[0];
        if (m_state == 4) begin
            if (k == -1) return m_idc[0];
            if (k == -2) return m_byp;
            return m_usr[k][0];
        end
        return 1'b0;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or posedge RESET);
            if (RESET) model_reset();
            else model_step();
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge
    initial forever begin
        @(negedge CLK);
        if (cmp_en) begin
            int k;
            k = selk(m_ir);
            check("state", 32'(state), 32'(m_state));
            check("ir", 32'(ir), 32'(m_ir));
            check("tdo", 32'(TDO), 32'(exp_tdo()));
            check("update_dr", 32'(update_dr), 32'(m_state == 8));
            check("update_ir", 32'(update_ir), 32'(m_state == 15));
            check("dr_sel", 32'(dr_sel), (k >= 0) ? (32'd1 << k) : 32'd0);
            check("dr_update_data", 32'(dr_update_data), 32'({m_upd[1], m_upd[0]}));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input logic tms, input logic tdi, output logic tdo_s);
        @(negedge CLK);
        tdo_s = TDO;
        TMS = tms;
        TDI = tdi;
        @(posedge CLK);
        #1;
    endtask

    task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b);
    endtask

    task automatic shift_ir(input int n, input logic [31:0] din, output logic [31:0] dout);
        logic b;
        dout = '0;
        tick(1'b1, 1'b0, b); tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
        for (int i = 0; i < n; i++) begin
            tick(i == n - 1, din[i], b);
            dout[i] = b;
        end
        tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b);
    endtask

    initial begin
        logic [31:0] dout;
        logic b;
        logic [7:0] din;

        // Reset state
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_state", 32'(state), 32'd0);
        check("rst_ir", 32'(ir), 32'd1);
        check("rst_upd", 32'(dr_update_data), 32'd0);
        check("rst_tdo", 32'(TDO), 32'd0);
        RESET = 1'b0;
        cmp_en = 1'b1;
        tick(1'b0, 1'b0, b);

        // IDCODE readout
        shift_dr(32, 32'h0, dout);
        check("idcode_read", dout, 32'h1000_0001);
        $display("scan idcode tdo=%08h", dout);

        // IR capture/update with opcode 2
        shift_ir(4, 32'h2, dout);
        check("ir_cap_bits", 32'(dout[1:0]), 32'h1);
        check("ir_after_upd", 32'(ir), 32'd2);
        check("dr_sel_user0", 32'(dr_sel), 32'h1);
        $display("scan ir=2 tdo=%01h", dout[3:0]);

        // User DR 0 write and readout
        dr_capture_data = {8'h77, 8'hA5};
        shift_dr(8, 32'h3C, dout);
        check("user0_read", 32'(dout[7:0]), 32'hA5);
        check("user_update", 32'(dr_update_data), 32'h003C);
        $display("scan user0 tdo=%02h upd=%04h", dout[7:0], dr_update_data);

        // BYPASS with all-ones opcode
        shift_ir(4, 32'hF, dout);
        check("ir_bypass", 32'(ir), 32'hF);
        check("dr_sel_bypass", 32'(dr_sel), 32'h0);
        shift_dr(4, 32'hD, dout);
        check("bypass_tdo", 32'(dout[3:0]), 32'hA);
        $display("scan bypass tdo=%01h", dout[3:0]);

        // TMS reset from SHIFT_IR with ir=3
        shift_ir(4, 32'h3, dout);
        check("dr_sel_user1", 32'(dr_sel), 32'h2);
        tick(1'b1, 1'b0, b); tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
        check("in_shift_ir", 32'(state), 32'd11);
        tick(1'b0, 1'b1, b); tick(1'b0, 1'b0, b);
        repeat (5) tick(1'b1, 1'b0, b);
        check("tms_reset_state", 32'(state), 32'd0);
        check("tms_reset_ir", 32'(ir), 32'd1);
        $display("tms reset state=%0d ir=%0d", state, ir);
        tick(1'b0, 1'b0, b);

        // DR scan through PAUSE_DR/EXIT2_DR
        shift_ir(4, 32'h2, dout);
        dr_capture_data = {8'h77, 8'h5A};
        din = 8'hC3;
        dout = '0;
        tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
        for (int i = 0; i < 3; i++) begin tick(i == 2, din[i], b); dout[i] = b; end
        tick(1'b0, 1'b0, b);
        check("pause_state", 32'(state), 32'd6);
        tick(1'b0, 1'b0, b); tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b);
        for (int i = 3; i < 8; i++) begin tick(i == 7, din[i], b); dout[i] = b; end
        tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b);
        check("pause_read", 32'(dout[7:0]), 32'h5A);
        check("pause_update", 32'(dr_update_data), 32'h00C3);
        $display("scan pause tdo=%02h upd=%04h", dout[7:0], dr_update_data);

        // Reset asserted in the middle of SHIFT_DR
        tick(1'b1, 1'b0, b); tick(1'b0, 1'b0, b); tick(1'b0, 1'b0, b);
        tick(1'b0, 1'b1, b); tick(1'b0, 1'b0, b);
        check("mid_shift_state", 32'(state), 32'd4);
        @(negedge CLK);
        #2 RESET = 1'b1;
        #1;
        check("midrst_state", 32'(state), 32'd0);
        check("midrst_ir", 32'(ir), 32'd1);
        check("midrst_upd", 32'(dr_update_data), 32'd0);
        check("midrst_tdo", 32'(TDO), 32'd0);
        check("midrst_sel", 32'(dr_sel), 32'd0);
        $display("reset mid-shift state=%0d ir=%0d upd=%04h", state, ir, dr_update_data);
        @(negedge CLK);
        RESET = 1'b0;
        TMS = 1'b1;
        repeat (3) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
